sac: RTL and testbench

- Parametrised read-only N-way set-associative cache.
- Next generation of the team's direct-mapped read-only cache; sits between the QSPI XIP controller fetch path and the bus-side read port.
- Lookup is combinational against the current address. Lines are filled by the flash-read engine.
- Adds per-set round-robin replacement, duplicate-free refill and a sequential whole-cache invalidate.

---
 rtl/sac.sv | 175 +++++++++++++++++
 tb/tb_sac.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sac.sv
// sac: read-only N-way set-associative cache with round-robin replacement.
// Optional hit/miss counters are compiled in with SAC_PERF_CNT_EN.
module sac #(
   parameter int NUM_SETS   = 8,
   parameter int NUM_WAYS   = 2,
   parameter int LINE_SIZE  = 16,
   parameter int ADDR_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  A,
   output logic [31:0]            Do,
   output logic                   hit,
   input  logic [LINE_SIZE*8-1:0] line,
   input  logic                   wr,
   input  logic                   inv,
   output logic                   busy,
   input  logic                   req
`ifdef SAC_PERF_CNT_EN
   ,
   output logic [31:0]            hit_cnt,
   output logic [31:0]            miss_cnt
`endif
);

   localparam int OFF = $clog2(LINE_SIZE);
   localparam int IDX = $clog2(NUM_SETS);
   localparam int TAG = ADDR_WIDTH - IDX - OFF;
   localparam int WW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int WPL = LINE_SIZE / 4;
   localparam int LW  = LINE_SIZE * 8;

   typedef enum logic {IDLE, SWEEP} state_e;

   logic [LW-1:0]       data_q  [NUM_SETS][NUM_WAYS];
   logic [TAG-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [WW-1:0]       rr_q    [NUM_SETS];

   state_e          state_q;
   logic [IDX-1:0]  ptr_q;
   logic            busy_q;

   logic [OFF-1:0]      off;
   logic [IDX-1:0]      set;
   logic [TAG-1:0]      tag;
   logic [NUM_WAYS-1:0] hit_w;
   logic                hit_any;
   logic [WW-1:0]       hit_way;
   logic                inv_found;
   logic [WW-1:0]       inv_way;
   logic [WW-1:0]       victim;
   logic                rr_adv;
   logic [WW-1:0]       rr_d;
   logic                fill;

   assign off  = A[OFF-1:0];
   assign set  = A[OFF+IDX-1:OFF];
   assign tag  = A[ADDR_WIDTH-1:OFF+IDX];
   assign busy = busy_q;
   assign fill = wr & ~busy_q;
   assign hit  = hit_any & ~busy_q;

   // Tag compare across all ways of the addressed set.
   always_comb begin
      hit_w   = '0;
      hit_way = '0;
      for (int k = 0; k < NUM_WAYS; k++) begin
         hit_w[k] = valid_q[set][k] && (tag_q[set][k] == tag);
         if (hit_w[k]) hit_way = WW'(k);
      end
      hit_any = |hit_w;
   end

   // Word select from the hitting line; zero on miss.
   always_comb begin
      Do = '0;
      if (hit) begin
         for (int w = 0; w < WPL; w++) begin
            if ((off >> 2) == OFF'(w)) Do = data_q[set][hit_way][32*w +: 32];
         end
      end
   end

   // Victim: resident way first, then lowest invalid way, then rr.
   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      for (int k = NUM_WAYS - 1; k >= 0; k--) begin
         if (!valid_q[set][k]) begin
            inv_found = 1'b1;
            inv_way   = WW'(k);
         end
      end
      rr_adv = 1'b0;
      if (hit_any) victim = hit_way;
      else if (inv_found) victim = inv_way;
      else begin
         victim = rr_q[set];
         rr_adv = 1'b1;
      end
      rr_d = (NUM_WAYS == 1) ? '0 : rr_q[set] + WW'(1);
   end

   // Line payload and tag; these arrays carry no reset.
   always_ff @(posedge clk) begin
      if (fill) begin
         data_q[set][victim] <= line;
         tag_q[set][victim]  <= tag;
      end
   end

   // Valid bits, rr pointers and the invalidate sweep FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
         state_q <= IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (fill) begin
                  valid_q[set][victim] <= 1'b1;
                  if (rr_adv) rr_q[set] <= rr_d;
               end
               if (inv) begin
                  state_q <= SWEEP;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SWEEP: begin
               valid_q[ptr_q] <= '0;
               rr_q[ptr_q]    <= '0;
               ptr_q          <= ptr_q + IDX'(1);
               if (ptr_q == IDX'(NUM_SETS - 1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SAC_PERF_CNT_EN
   // Saturating hit/miss counters for qualified lookups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state_q == IDLE && inv) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (req && !busy_q) begin
         if (hit) begin
            if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
         end else begin
            if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`else
   logic unused_req;
   assign unused_req = req;
`endif

endmodule

// File: tb/tb_sac.sv
// tb_sac: table-driven checks of sac lookup, fill, replacement
// and the invalidate sweep, with a small expected-result queue.
module tb_sac;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [23:0]  A;
   logic [31:0]  Do;
   logic         hit;
   logic [127:0] line;
   logic         wr;
   logic         inv;
   logic         busy;
   logic         req;
`ifdef SAC_PERF_CNT_EN
   logic [31:0]  hit_cnt;
   logic [31:0]  miss_cnt;
`endif

   int checks = 0;
   int errors = 0;

   sac #(
      .NUM_SETS   (4),
      .NUM_WAYS   (2),
      .LINE_SIZE  (16),
      .ADDR_WIDTH (24)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .A        (A),
      .Do       (Do),
      .hit      (hit),
      .line     (line),
      .wr       (wr),
      .inv      (inv),
      .busy     (busy),
      .req      (req)
`ifdef SAC_PERF_CNT_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef enum {OP_FILL, OP_LOOK} op_e;

   typedef struct {
      op_e          op;
      logic [23:0]  addr;
      logic [127:0] data;
      logic         eh;
      logic [31:0]  ed;
      string        nm;
   } vec_t;

   typedef struct {
      logic        h;
      logic [31:0] d;
      string       nm;
   } exp_t;

   vec_t vt[$];
   exp_t sb[$];

   function automatic logic [127:0] mk(input logic [31:0] b);
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic fill(input logic [23:0] a, input logic [127:0] d);
      @(negedge clk);
      A    = a;
      line = d;
      wr   = 1'b1;
      @(negedge clk);
      wr   = 1'b0;
   endtask

   task automatic look(input logic [23:0] a, input logic eh,
                       input logic [31:0] ed, input string nm);
      exp_t e;
      @(negedge clk);
      A = a;
      sb.push_back('{eh, ed, nm});
      #1;
      e = sb.pop_front();
      chk({e.nm, " hit"}, {31'd0, hit}, {31'd0, e.h});
      chk({e.nm, " do"}, Do, e.d);
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk({nm, " idle"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic addv(input op_e op, input logic [23:0] a,
                       input logic [127:0] d, input logic eh,
                       input logic [31:0] ed, input string nm);
      vt.push_back('{op, a, d, eh, ed, nm});
   endtask

   initial begin
      int  nb;
      bit  fell;

      rst_n = 1'b0;
      A     = 24'h000010;
      line  = '0;
      wr    = 1'b0;
      inv   = 1'b0;
      req   = 1'b0;
      #1;
      chk("rst hit", {31'd0, hit}, 32'd0);
      chk("rst do", Do, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      addv(OP_LOOK, 24'h000010, '0, 1'b0, 32'h0, "empty");
      addv(OP_FILL, 24'h000010,
           128'h44444444_33333333_22222222_11111111, 1'b0, 0, "");
      addv(OP_LOOK, 24'h000018, '0, 1'b1, 32'h33333333, "w2");
      addv(OP_LOOK, 24'h00001C, '0, 1'b1, 32'h44444444, "w3");
      addv(OP_LOOK, 24'h000014, '0, 1'b1, 32'h22222222, "w1");
      addv(OP_FILL, 24'h000050, mk(32'hA000), 1'b0, 0, "");
      addv(OP_LOOK, 24'h000050, '0, 1'b1, 32'hA000, "way1");
      addv(OP_LOOK, 24'h000010, '0, 1'b1, 32'h11111111, "way0");
      addv(OP_FILL, 24'h000090, mk(32'hB000), 1'b0, 0, "");
      addv(OP_LOOK, 24'h000010, '0, 1'b0, 32'h0, "evict0");
      addv(OP_LOOK, 24'h000054, '0, 1'b1, 32'hA001, "keep50");
      addv(OP_LOOK, 24'h000098, '0, 1'b1, 32'hB002, "new90");
      addv(OP_FILL, 24'h0000D0, mk(32'hC000), 1'b0, 0, "");
      addv(OP_LOOK, 24'h000050, '0, 1'b0, 32'h0, "evict1");
      addv(OP_LOOK, 24'h00009C, '0, 1'b1, 32'hB003, "keep90");
      addv(OP_LOOK, 24'h0000D0, '0, 1'b1, 32'hC000, "newD0");
      addv(OP_FILL, 24'h000090, mk(32'hD000), 1'b0, 0, "");
      addv(OP_LOOK, 24'h000090, '0, 1'b1, 32'hD000, "refill");
      addv(OP_LOOK, 24'h0000D4, '0, 1'b1, 32'hC001, "refill other");
      addv(OP_FILL, 24'h000010, mk(32'hE000), 1'b0, 0, "");
      addv(OP_LOOK, 24'h000090, '0, 1'b0, 32'h0, "rr kept");
      addv(OP_LOOK, 24'h0000D0, '0, 1'b1, 32'hC000, "rr kept D0");
      addv(OP_LOOK, 24'h000010, '0, 1'b1, 32'hE000, "rr kept 10");
      addv(OP_FILL, 24'h000020, mk(32'hF000), 1'b0, 0, "");
      addv(OP_FILL, 24'h000038, mk(32'h1000), 1'b0, 0, "");
      addv(OP_FILL, 24'h000000, mk(32'h2000), 1'b0, 0, "");
      addv(OP_FILL, 24'hFFFFF0, mk(32'h3000), 1'b0, 0, "");
      addv(OP_LOOK, 24'h00002C, '0, 1'b1, 32'hF003, "set2");
      addv(OP_LOOK, 24'h000030, '0, 1'b1, 32'h1000, "set3");
      addv(OP_LOOK, 24'h000008, '0, 1'b1, 32'h2002, "set0");
      addv(OP_LOOK, 24'hFFFFF4, '0, 1'b1, 32'h3001, "toptag");
      addv(OP_LOOK, 24'h000034, '0, 1'b1, 32'h1001, "set3 w0");

      foreach (vt[i]) begin
         if (vt[i].op == OP_FILL) fill(vt[i].addr, vt[i].data);
         else look(vt[i].addr, vt[i].eh, vt[i].ed, vt[i].nm);
      end

      // Sweep with inv held three cycles and a write mid-sweep.
      @(negedge clk);
      A   = 24'h0000D0;
      inv = 1'b1;
      #1;
      chk("pre sweep hit", {31'd0, hit}, 32'd1);
      nb   = 0;
      fell = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 1) begin
            A    = 24'h000040;
            line = mk(32'h4000);
            wr   = 1'b1;
         end
         if (c == 2) begin
            inv = 1'b0;
            wr  = 1'b0;
            A   = 24'h0000D0;
         end
         #1;
         if (busy) begin
            nb++;
            chk("sweep hit", {31'd0, hit}, 32'd0);
         end else begin
            fell = 1'b1;
            break;
         end
      end
      inv = 1'b0;
      wr  = 1'b0;
      chk("busy cycles", nb, 32'd4);
      chk("busy fell", {31'd0, fell}, 32'd1);
      look(24'h000040, 1'b0, 32'h0, "wr in sweep");
      look(24'h0000D0, 1'b0, 32'h0, "swept D0");
      look(24'h000010, 1'b0, 32'h0, "swept 10");
      look(24'h000020, 1'b0, 32'h0, "swept 20");
      look(24'h000030, 1'b0, 32'h0, "swept 30");
      look(24'h000000, 1'b0, 32'h0, "swept 00");
      look(24'hFFFFF0, 1'b0, 32'h0, "swept top");

      // rr must restart at 0 after the sweep.
      fill(24'h000010, mk(32'h5000));
      fill(24'h000050, mk(32'h5100));
      fill(24'h000090, mk(32'h5200));
      look(24'h000010, 1'b0, 32'h0, "rr0 evict");
      look(24'h000050, 1'b1, 32'h5100, "rr0 keep");

      // Fill and inv at the same edge: sweep clears the new line.
      @(negedge clk);
      A    = 24'h000020;
      line = mk(32'h6000);
      wr   = 1'b1;
      inv  = 1'b1;
      @(negedge clk);
      wr   = 1'b0;
      inv  = 1'b0;
      #1;
      chk("wr+inv busy", {31'd0, busy}, 32'd1);
      chk("wr+inv hit", {31'd0, hit}, 32'd0);
      wait_idle("wr+inv");
      look(24'h000020, 1'b0, 32'h0, "wr+inv gone");

`ifdef SAC_PERF_CNT_EN
      fill(24'h000010, mk(32'h6100));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         A   = (i < 3) ? 24'h000010 : 24'h000020;
         req = 1'b1;
      end
      @(negedge clk);
      req = 1'b0;
      #1;
      chk("hit_cnt", hit_cnt, 32'd3);
      chk("miss_cnt", miss_cnt, 32'd2);
      @(negedge clk);
      inv = 1'b1;
      @(negedge clk);
      inv = 1'b0;
      #1;
      chk("inv hit_cnt", hit_cnt, 32'd0);
      chk("inv miss_cnt", miss_cnt, 32'd0);
      wait_idle("cnt sweep");
      @(negedge clk);
      A   = 24'h000020;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      #1;
      chk("miss one", miss_cnt, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst miss_cnt", miss_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      // Asynchronous reset in the middle of a sweep.
      fill(24'h000010, mk(32'h7000));
      @(negedge clk);
      inv = 1'b1;
      @(negedge clk);
      inv = 1'b0;
      @(negedge clk);
      #1;
      chk("mid sweep busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort hit", {31'd0, hit}, 32'd0);
`ifdef SAC_PERF_CNT_EN
      chk("abort hit_cnt", hit_cnt, 32'd0);
      chk("abort miss_cnt", miss_cnt, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      fill(24'h000010, mk(32'h8000));
      look(24'h00001C, 1'b1, 32'h8003, "post abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
